// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for a single-port
// synchronous RAM with 1-cycle read latency.
module mem_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    // state | meaning
    // IDLE  | sampling requests; ack of the previous access is visible here
    // ACC   | RAM enabled with the captured address/data
    // RESP  | read data arriving from RAM; ack issued on exit
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t state;
    logic   gnt;
    logic   last;
    logic   rd;
    logic   win;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (req0 && req1) win = ~last;
        else              win = req1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt       <= 1'b0;
            rd        <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt       <= win;
                        last      <= win;
                        rd        <= win ? ~we1 : ~we0;
                        mem_en    <= 1'b1;
                        mem_we    <= win ? we1 : we0;
                        mem_addr  <= win ? addr1 : addr0;
                        mem_wdata <= win ? wdata1 : wdata0;
                        state     <= ACC;
                    end else begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                    end
                end
                ACC: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= RESP;
                end
                RESP: begin
                    if (rd) rdata <= mem_rdata;
                    if (gnt) ack1 <= 1'b1;
                    else     ack0 <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, transaction-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_mem_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, mem_en, mem_we;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM with 1-cycle read latency
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model: an access occupies 3 cycles after its start edge;
    // left counts the cycles of it still to be shown (3 = RAM enabled,
    // 2 = waiting on read data, 1 = ack visible, new request may start).
    int            m_left = 0;
    logic          m_last = 1'b1;
    logic          m_gnt = 1'b0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] m_res = '0;
    logic [DW-1:0] shadow [16];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left  = 0;
            m_last  = 1'b1;
            m_we    = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
            m_rdata = '0;
        end else if (m_left <= 1 && (req0 || req1)) begin
            m_gnt   = (req0 && req1) ? !m_last : req1;
            m_last  = m_gnt;
            m_we    = m_gnt ? we1 : we0;
            m_addr  = m_gnt ? addr1 : addr0;
            m_wdata = m_gnt ? wdata1 : wdata0;
            if (m_we) shadow[m_addr] = m_wdata;
            else      m_res = shadow[m_addr];
            m_left  = 3;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 1 && !m_we) m_rdata = m_res;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m.ack0", 32'(ack0), 32'(m_left == 1 && !m_gnt));
            check("m.ack1", 32'(ack1), 32'(m_left == 1 && m_gnt));
            check("m.busy", 32'(busy), 32'(m_left >= 2));
            check("m.mem_en", 32'(mem_en), 32'(m_left == 3));
            check("m.mem_we", 32'(mem_we), 32'(m_left == 3 && m_we));
            check("m.mem_addr", 32'(mem_addr), 32'(m_addr));
            check("m.mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            check("m.rdata", 32'(rdata), 32'(m_rdata));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, ".ack0"}, 32'(ack0), 32'h0);
        check({nm, ".ack1"}, 32'(ack1), 32'h0);
        check({nm, ".busy"}, 32'(busy), 32'h0);
        check({nm, ".mem_en"}, 32'(mem_en), 32'h0);
        check({nm, ".mem_we"}, 32'(mem_we), 32'h0);
        check({nm, ".mem_addr"}, 32'(mem_addr), 32'h0);
        check({nm, ".mem_wdata"}, 32'(mem_wdata), 32'h0);
        check({nm, ".rdata"}, 32'(rdata), 32'h0);
    endtask

    task automatic access(input bit who, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat);
        lat = 0;
        if (!who) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else      begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        do begin
            step(1);
            lat++;
        end while (!(who ? ack1 : ack0) && lat < 10);
        if (!who) req0 = 1'b0;
        else      req1 = 1'b0;
    endtask

    int ack_who [8];
    int ack_when [8];
    int n_acks;
    bit overlap;

    task automatic serve_both(input int cycles, input bit drop);
        n_acks  = 0;
        overlap = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 1; i <= cycles; i++) begin
            step(1);
            if (ack0 && ack1) overlap = 1'b1;
            if (ack0 && n_acks < 8) begin
                ack_who[n_acks] = 0; ack_when[n_acks] = i; n_acks++;
                if (drop) req0 = 1'b0;
            end
            if (ack1 && n_acks < 8) begin
                ack_who[n_acks] = 1; ack_when[n_acks] = i; n_acks++;
                if (drop) req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    int lat;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i]    = 8'(i * 29 + 7);
            shadow[i] = 8'(i * 29 + 7);
        end
        ram[3]    = 8'hA5;
        shadow[3] = 8'hA5;

        // reset held with random inputs
        #1 rst = 1'b0;
        #1 chk_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0 = 1'($urandom); req1 = 1'($urandom);
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = 4'($urandom); addr1 = 4'($urandom);
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            step(1);
            check_all_zero("rst_hold");
        end
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_all_zero("rst_idle");
        end

        // first tie after reset: requester 0 first, then 1
        addr0 = 4'd3; addr1 = 4'd7;
        serve_both(8, 1'b1);
        check("tie.n", 32'(n_acks), 32'd2);
        check("tie.who0", 32'(ack_who[0]), 32'd0);
        check("tie.when0", 32'(ack_when[0]), 32'd3);
        check("tie.who1", 32'(ack_who[1]), 32'd1);
        check("tie.when1", 32'(ack_when[1]), 32'd6);
        check("tie.overlap", 32'(overlap), 32'd0);

        // sustained contention for 12 cycles
        addr0 = 4'd1; addr1 = 4'd2;
        serve_both(12, 1'b0);
        check("sus.n", 32'(n_acks), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("sus.who", 32'(ack_who[k]), 32'(k % 2));
            check("sus.when", 32'(ack_when[k]), 32'(3 * (k + 1)));
        end
        check("sus.overlap", 32'(overlap), 32'd0);
        step(2);

        // single read of address 3
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        step(1);
        check("rd.mem_en", 32'(mem_en), 32'h1);
        check("rd.mem_addr", 32'(mem_addr), 32'h3);
        step(1);
        check("rd.busy", 32'(busy), 32'h1);
        step(1);
        check("rd.ack0", 32'(ack0), 32'h1);
        check("rd.ack1", 32'(ack1), 32'h0);
        check("rd.rdata", 32'(rdata), 32'hA5);
        check("rd.busy_ack", 32'(busy), 32'h0);
        req0 = 1'b0;
        step(1);
        check("rd.ack0_clr", 32'(ack0), 32'h0);

        // write by requester 1, read back by requester 0
        access(1'b1, 1'b1, 4'd9, 8'h3C, lat);
        check("wr.lat", 32'(lat), 32'd3);
        check("wr.rdata_held", 32'(rdata), 32'hA5);
        step(1);
        access(1'b0, 1'b0, 4'd9, 8'h00, lat);
        check("rb.lat", 32'(lat), 32'd3);
        check("rb.rdata", 32'(rdata), 32'h3C);
        step(1);

        // reset while in RESP
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd4;
        step(2);
        check("mid.busy_pre", 32'(busy), 32'h1);
        #1 rst = 1'b0;
        #1;
        check("mid.mem_en", 32'(mem_en), 32'h0);
        check("mid.ack0", 32'(ack0), 32'h0);
        check("mid.rdata", 32'(rdata), 32'h0);
        check("mid.busy", 32'(busy), 32'h0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd6;
        for (int i = 0; i < 2; i++) begin
            step(1);
            check("mid.no_ack0", 32'(ack0), 32'h0);
            check("mid.no_ack1", 32'(ack1), 32'h0);
        end
        rst = 1'b1;
        serve_both(8, 1'b1);
        check("mid_tie.n", 32'(n_acks), 32'd2);
        check("mid_tie.who0", 32'(ack_who[0]), 32'd0);
        check("mid_tie.when0", 32'(ack_when[0]), 32'd3);
        check("mid_tie.who1", 32'(ack_who[1]), 32'd1);
        check("mid_tie.when1", 32'(ack_when[1]), 32'd6);
        step(2);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
